// File: rtl/wb_exc_ctrl.sv
// rtl/wb_exc_ctrl.sv - WB-stage exception/ertn commit sequencer and front-end redirect
module wb_exc_ctrl #(
   parameter int unsigned FLUSH_MIN = 1  // minimum cycles spent in REDIRECT, 1..15
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        wb_valid_i,
   input  logic [31:0] wb_pc_i,
   input  logic [31:0] wb_vaddr_i,
   input  logic        wb_int_i,
   input  logic [5:0]  wb_exc_i,
   input  logic        wb_ertn_i,
   input  logic [31:0] ex_entry_i,
   input  logic [31:0] ertn_entry_i,
   input  logic        preif_ready_i,
   output logic        csr_wb_ex_o,
   output logic        csr_ertn_flush_o,
   output logic [5:0]  csr_wb_ecode_o,
   output logic [8:0]  csr_wb_esubcode_o,
   output logic [31:0] csr_wb_pc_o,
   output logic [31:0] csr_wb_vaddr_o,
   output logic        pipe_flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic        wb_allowin_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COMMIT   = 2'd1,
      S_REDIRECT = 2'd2
   } state_e;

   localparam logic [3:0] CNT_LAST = 4'(FLUSH_MIN - 1);

   state_e      state_q, state_d;
   logic        is_ex_q, is_ex_d;     // 1: exception commit, 0: ertn commit
   logic [5:0]  ecode_q, ecode_d;
   logic [8:0]  esub_q, esub_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] vaddr_q, vaddr_d;
   logic [31:0] target_q, target_d;
   logic [3:0]  cnt_q, cnt_d;

   logic        trigger;
   logic        sel_ex;
   logic [5:0]  sel_ecode;
   logic [8:0]  sel_esub;

   assign trigger = wb_valid_i & (wb_int_i | (|wb_exc_i) | wb_ertn_i);

   // Priority pick of the retiring instruction's cause; ertn only if nothing else is pending
   always_comb begin
      sel_ex    = 1'b1;
      sel_ecode = 6'h00;
      sel_esub  = 9'd0;
      if (wb_int_i) begin
         sel_ecode = 6'h00;
      end else if (wb_exc_i[0]) begin
         sel_ecode = 6'h08;
      end else if (wb_exc_i[1]) begin
         sel_ecode = 6'h0D;
      end else if (wb_exc_i[2]) begin
         sel_ecode = 6'h0B;
      end else if (wb_exc_i[3]) begin
         sel_ecode = 6'h0C;
      end else if (wb_exc_i[4]) begin
         sel_ecode = 6'h09;
      end else if (wb_exc_i[5]) begin
         sel_ecode = 6'h08;
         sel_esub  = 9'd1;
      end else begin
         sel_ex    = 1'b0;
      end
   end

   // Next-state and output decode; outputs are pure functions of state so reset clears them at once
   always_comb begin
      state_d            = state_q;
      is_ex_d            = is_ex_q;
      ecode_d            = ecode_q;
      esub_d             = esub_q;
      pc_d               = pc_q;
      vaddr_d            = vaddr_q;
      target_d           = target_q;
      cnt_d              = cnt_q;
      csr_wb_ex_o        = 1'b0;
      csr_ertn_flush_o   = 1'b0;
      pipe_flush_o       = 1'b0;
      redirect_valid_o   = 1'b0;
      wb_allowin_o       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            wb_allowin_o = 1'b1;
            if (trigger) begin
               is_ex_d = sel_ex;
               ecode_d = sel_ecode;
               esub_d  = sel_esub;
               pc_d    = wb_pc_i;
               vaddr_d = wb_vaddr_i;
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            csr_wb_ex_o      = is_ex_q;
            csr_ertn_flush_o = ~is_ex_q;
            pipe_flush_o     = 1'b1;
            target_d         = is_ex_q ? ex_entry_i : ertn_entry_i;
            cnt_d            = 4'd0;
            state_d          = S_REDIRECT;
         end
         S_REDIRECT: begin
            redirect_valid_o = 1'b1;
            pipe_flush_o     = 1'b1;
            if (cnt_q < CNT_LAST) begin
               cnt_d = cnt_q + 4'd1;
            end
            if (preif_ready_i && (cnt_q == CNT_LAST)) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and capture registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         is_ex_q  <= 1'b0;
         ecode_q  <= 6'h00;
         esub_q   <= 9'd0;
         pc_q     <= 32'h0;
         vaddr_q  <= 32'h0;
         target_q <= 32'h0;
         cnt_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         is_ex_q  <= is_ex_d;
         ecode_q  <= ecode_d;
         esub_q   <= esub_d;
         pc_q     <= pc_d;
         vaddr_q  <= vaddr_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

   assign csr_wb_ecode_o    = ecode_q;
   assign csr_wb_esubcode_o = esub_q;
   assign csr_wb_pc_o       = pc_q;
   assign csr_wb_vaddr_o    = vaddr_q;
   assign redirect_pc_o     = target_q;

endmodule

// File: tb/tb_wb_exc_ctrl.sv
// tb/tb_wb_exc_ctrl.sv - directed checks of wb_exc_ctrl at FLUSH_MIN 1 and 3
module tb_wb_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        wb_valid, wb_valid3;
   logic [31:0] wb_pc, wb_vaddr;
   logic        wb_int;
   logic [5:0]  wb_exc;
   logic        wb_ertn;
   logic [31:0] ex_entry, ertn_entry;
   logic        preif_ready;

   logic        ex1, ertn1, pf1, rv1, al1;
   logic [5:0]  ec1;
   logic [8:0]  es1;
   logic [31:0] cpc1, cva1, rpc1;
   logic        ex3, ertn3, pf3, rv3, al3;
   logic [5:0]  ec3;
   logic [8:0]  es3;
   logic [31:0] cpc3, cva3, rpc3;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_exc_ctrl #(.FLUSH_MIN(1)) dut1 (
      .clk_i(clk), .reset_i(reset_i), .wb_valid_i(wb_valid), .wb_pc_i(wb_pc),
      .wb_vaddr_i(wb_vaddr), .wb_int_i(wb_int), .wb_exc_i(wb_exc), .wb_ertn_i(wb_ertn),
      .ex_entry_i(ex_entry), .ertn_entry_i(ertn_entry), .preif_ready_i(preif_ready),
      .csr_wb_ex_o(ex1), .csr_ertn_flush_o(ertn1), .csr_wb_ecode_o(ec1),
      .csr_wb_esubcode_o(es1), .csr_wb_pc_o(cpc1), .csr_wb_vaddr_o(cva1),
      .pipe_flush_o(pf1), .redirect_valid_o(rv1), .redirect_pc_o(rpc1), .wb_allowin_o(al1)
   );

   wb_exc_ctrl #(.FLUSH_MIN(3)) dut3 (
      .clk_i(clk), .reset_i(reset_i), .wb_valid_i(wb_valid3), .wb_pc_i(wb_pc),
      .wb_vaddr_i(wb_vaddr), .wb_int_i(wb_int), .wb_exc_i(wb_exc), .wb_ertn_i(wb_ertn),
      .ex_entry_i(ex_entry), .ertn_entry_i(ertn_entry), .preif_ready_i(preif_ready),
      .csr_wb_ex_o(ex3), .csr_ertn_flush_o(ertn3), .csr_wb_ecode_o(ec3),
      .csr_wb_esubcode_o(es3), .csr_wb_pc_o(cpc3), .csr_wb_vaddr_o(cva3),
      .pipe_flush_o(pf3), .redirect_valid_o(rv3), .redirect_pc_o(rpc3), .wb_allowin_o(al3)
   );

   typedef struct {
      logic        intr;
      logic [5:0]  exc;
      logic        ertn;
      logic [31:0] pc;
      logic [31:0] vaddr;
      logic [31:0] ex_e;
      logic [31:0] ertn_e;
      logic        x_ex;
      logic        x_ertn;
      logic [5:0]  x_ecode;
      logic [8:0]  x_esub;
      logic [31:0] x_target;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      wb_valid = 1'b0;
      wb_valid3 = 1'b0;
      wb_int = 1'b0;
      wb_exc = 6'b0;
      wb_ertn = 1'b0;
   endtask

   // One trigger on the FLUSH_MIN=1 instance with preif_ready high; starts and ends just after a posedge
   task automatic run_vec(input vec_t v);
      wb_valid = 1'b1;
      wb_int = v.intr;
      wb_exc = v.exc;
      wb_ertn = v.ertn;
      wb_pc = v.pc;
      wb_vaddr = v.vaddr;
      ex_entry = v.ex_e;
      ertn_entry = v.ertn_e;
      preif_ready = 1'b1;
      @(negedge clk);
      chk("idle_allowin", 32'(al1), 32'd1);
      chk("idle_flush", 32'(pf1), 32'd0);
      step();
      clear_in();
      @(negedge clk);
      chk("commit_ex", 32'(ex1), 32'(v.x_ex));
      chk("commit_ertn", 32'(ertn1), 32'(v.x_ertn));
      chk("commit_ecode", 32'(ec1), 32'(v.x_ecode));
      chk("commit_esub", 32'(es1), 32'(v.x_esub));
      chk("commit_pc", cpc1, v.pc);
      chk("commit_vaddr", cva1, v.vaddr);
      chk("commit_flush", 32'(pf1), 32'd1);
      chk("commit_allowin", 32'(al1), 32'd0);
      chk("commit_rvalid", 32'(rv1), 32'd0);
      step();
      ex_entry = 32'hdeadbeef;
      ertn_entry = 32'hbadc0de0;
      @(negedge clk);
      chk("redir_valid", 32'(rv1), 32'd1);
      chk("redir_pc", rpc1, v.x_target);
      chk("redir_flush", 32'(pf1), 32'd1);
      chk("redir_allowin", 32'(al1), 32'd0);
      chk("redir_ex", 32'(ex1 | ertn1), 32'd0);
      step();
      @(negedge clk);
      chk("post_allowin", 32'(al1), 32'd1);
      chk("post_rvalid", 32'(rv1), 32'd0);
      chk("post_flush", 32'(pf1), 32'd0);
      chk("post_hold_ecode", 32'(ec1), 32'(v.x_ecode));
      chk("post_hold_pc", cpc1, v.pc);
      step();
   endtask

   initial begin
      int n;
      vecs[0] = '{1'b0, 6'b000100, 1'b0, 32'h1c000100, 32'h0, 32'h1c008000, 32'h1c000200,
                  1'b1, 1'b0, 6'h0B, 9'd0, 32'h1c008000};
      vecs[1] = '{1'b1, 6'b111111, 1'b0, 32'h1c000110, 32'h55, 32'h1c008000, 32'h1c000200,
                  1'b1, 1'b0, 6'h00, 9'd0, 32'h1c008000};
      vecs[2] = '{1'b0, 6'b100000, 1'b0, 32'h1c000120, 32'h77, 32'h1c008100, 32'h1c000200,
                  1'b1, 1'b0, 6'h08, 9'd1, 32'h1c008100};
      vecs[3] = '{1'b0, 6'b010000, 1'b0, 32'h1c000130, 32'h1234, 32'h1c008000, 32'h1c000200,
                  1'b1, 1'b0, 6'h09, 9'd0, 32'h1c008000};
      vecs[4] = '{1'b0, 6'b000000, 1'b1, 32'h1c000140, 32'h0, 32'h1c008000, 32'h1c000200,
                  1'b0, 1'b1, 6'h00, 9'd0, 32'h1c000200};
      vecs[5] = '{1'b0, 6'b000010, 1'b1, 32'h1c000150, 32'h0, 32'h1c008000, 32'h1c000200,
                  1'b1, 1'b0, 6'h0D, 9'd0, 32'h1c008000};
      vecs[6] = '{1'b0, 6'b000011, 1'b0, 32'h1c000160, 32'h0, 32'h1c008200, 32'h1c000200,
                  1'b1, 1'b0, 6'h08, 9'd0, 32'h1c008200};
      vecs[7] = '{1'b0, 6'b011000, 1'b0, 32'h1c000170, 32'h9, 32'h1c008000, 32'h1c000200,
                  1'b1, 1'b0, 6'h0C, 9'd0, 32'h1c008000};
      vecs[8] = '{1'b0, 6'b000110, 1'b0, 32'h1c000180, 32'h0, 32'h1c008000, 32'h1c000200,
                  1'b1, 1'b0, 6'h0D, 9'd0, 32'h1c008000};

      reset_i = 1'b1;
      clear_in();
      wb_pc = 32'h0;
      wb_vaddr = 32'h0;
      ex_entry = 32'h0;
      ertn_entry = 32'h0;
      preif_ready = 1'b1;
      @(negedge clk);
      chk("rst_allowin", 32'(al1), 32'd1);
      chk("rst_outs", 32'({ex1, ertn1, pf1, rv1}), 32'd0);
      chk("rst_ecode", 32'(ec1), 32'd0);
      chk("rst_rpc", rpc1, 32'd0);
      chk("rst_cpc", cpc1, 32'd0);
      step();
      reset_i = 1'b0;
      step();

      // No trigger without wb_valid, and a plain retiring instruction does not stall
      wb_exc = 6'b000100;
      step();
      wb_exc = 6'b0;
      wb_valid = 1'b1;
      @(negedge clk);
      chk("notrig_allowin", 32'(al1), 32'd1);
      chk("notrig_flush", 32'(pf1), 32'd0);
      step();
      wb_valid = 1'b0;
      @(negedge clk);
      chk("plain_allowin", 32'(al1), 32'd1);
      chk("plain_ex", 32'(ex1), 32'd0);
      step();

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
      end

      // Reset during REDIRECT while pre-IF is stalled
      wb_valid = 1'b1;
      wb_exc = 6'b001000;
      wb_pc = 32'h1c000300;
      ex_entry = 32'h1c008000;
      preif_ready = 1'b0;
      step();
      clear_in();
      @(negedge clk);
      chk("rstseq_commit", 32'(ex1), 32'd1);
      step();
      @(negedge clk);
      chk("rstseq_redir", 32'(rv1), 32'd1);
      #2;
      reset_i = 1'b1;
      #1;
      chk("rstseq_rvalid", 32'(rv1), 32'd0);
      chk("rstseq_flush", 32'(pf1), 32'd0);
      chk("rstseq_allowin", 32'(al1), 32'd1);
      chk("rstseq_ex", 32'(ex1), 32'd0);
      step();
      reset_i = 1'b0;
      preif_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstseq_nopulse", 32'({ex1, ertn1, rv1}), 32'd0);
         chk("rstseq_idle", 32'(al1), 32'd1);
         step();
      end
      run_vec(vecs[0]);

      // Back-to-back: second instruction waits for the first IDLE cycle
      wb_valid = 1'b1;
      wb_exc = 6'b000100;
      wb_pc = 32'h1c000400;
      ex_entry = 32'h1c008000;
      step();
      wb_exc = 6'b001000;
      wb_pc = 32'h1c000404;
      @(negedge clk);
      chk("b2b_c1_ex", 32'(ex1), 32'd1);
      chk("b2b_c1_ecode", 32'(ec1), 32'h0B);
      chk("b2b_c1_pc", cpc1, 32'h1c000400);
      step();
      @(negedge clk);
      chk("b2b_redir_allowin", 32'(al1), 32'd0);
      chk("b2b_redir_ex", 32'(ex1), 32'd0);
      chk("b2b_redir_ecode", 32'(ec1), 32'h0B);
      step();
      @(negedge clk);
      chk("b2b_idle_allowin", 32'(al1), 32'd1);
      chk("b2b_idle_ex", 32'(ex1), 32'd0);
      step();
      clear_in();
      @(negedge clk);
      chk("b2b_c2_ex", 32'(ex1), 32'd1);
      chk("b2b_c2_ecode", 32'(ec1), 32'h0C);
      chk("b2b_c2_pc", cpc1, 32'h1c000404);
      step();
      @(negedge clk);
      chk("b2b_c2_redir", 32'(rv1), 32'd1);
      chk("b2b_c2_noex", 32'(ex1), 32'd0);
      step();
      @(negedge clk);
      chk("b2b_done", 32'(al1), 32'd1);
      step();

      // FLUSH_MIN=3: pre-IF stalls 5 REDIRECT cycles, ready on the 6th
      preif_ready = 1'b0;
      wb_valid3 = 1'b1;
      wb_exc = 6'b000100;
      wb_pc = 32'h1c000500;
      ex_entry = 32'h1c009000;
      step();
      clear_in();
      @(negedge clk);
      chk("bp_commit_ex", 32'(ex3), 32'd1);
      chk("bp_commit_flush", 32'(pf3), 32'd1);
      step();
      ex_entry = 32'hdeadbeef;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_stall_rvalid", 32'(rv3), 32'd1);
         chk("bp_stall_flush", 32'(pf3), 32'd1);
         chk("bp_stall_allowin", 32'(al3), 32'd0);
         chk("bp_stall_rpc", rpc3, 32'h1c009000);
         step();
      end
      preif_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_rvalid", 32'(rv3), 32'd1);
      chk("bp_ready_rpc", rpc3, 32'h1c009000);
      step();
      @(negedge clk);
      chk("bp_exit_rvalid", 32'(rv3), 32'd0);
      chk("bp_exit_allowin", 32'(al3), 32'd1);
      step();

      // FLUSH_MIN=3 with pre-IF always ready: REDIRECT lasts exactly 3 cycles
      wb_valid3 = 1'b1;
      wb_ertn = 1'b1;
      ertn_entry = 32'h1c000600;
      step();
      clear_in();
      @(negedge clk);
      chk("fm3_commit_ertn", 32'(ertn3), 32'd1);
      chk("fm3_commit_ex", 32'(ex3), 32'd0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         if (rv3) begin
            n++;
            chk("fm3_flush", 32'(pf3), 32'd1);
            chk("fm3_rpc", rpc3, 32'h1c000600);
         end else begin
            break;
         end
      end
      chk("fm3_redirect_cycles", 32'(n), 32'd3);
      chk("fm3_exit_allowin", 32'(al3), 32'd1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
